// File: rtl/tl_ul_master_engine.sv
// TileLink-UL single-beat master: turns a command stream into A-channel Get/PutFullData beats,
// tracks up to 2**SRC_SIZE in-flight accesses by source ID and returns D beats as a response stream.
module tl_ul_master_engine #(
    parameter int SRC_SIZE  = 2,
    parameter int SINK_SIZE = 2,
    parameter int BUS_SIZE  = 8,
    parameter int ADR_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    // Every stream below transfers on a cycle where valid & ready are both high; a producer holds
    // valid and its payload unchanged until that cycle.
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [3:0]             cmd_size,
    input  logic [ADR_WIDTH-1:0]   cmd_address,
    input  logic [BUS_SIZE-1:0]    cmd_mask,
    input  logic [8*BUS_SIZE-1:0]  cmd_data,
    input  logic                   a_ready,
    output logic                   a_valid,
    output logic [2:0]             a_bits_opcode,
    output logic [2:0]             a_bits_param,
    output logic [3:0]             a_bits_size,
    output logic [SRC_SIZE-1:0]    a_bits_source,
    output logic [ADR_WIDTH-1:0]   a_bits_address,
    output logic [BUS_SIZE-1:0]    a_bits_mask,
    output logic [8*BUS_SIZE-1:0]  a_bits_data,
    output logic                   a_bits_corrupt,
    output logic                   d_ready,
    input  logic                   d_valid,
    input  logic [2:0]             d_bits_opcode,
    input  logic [1:0]             d_bits_param,
    input  logic [3:0]             d_bits_size,
    input  logic [SRC_SIZE-1:0]    d_bits_source,
    input  logic [SINK_SIZE-1:0]   d_bits_sink,
    input  logic                   d_bits_denied,
    input  logic [8*BUS_SIZE-1:0]  d_bits_data,
    input  logic                   d_bits_corrupt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [SRC_SIZE-1:0]    rsp_source,
    output logic                   rsp_write,
    output logic [8*BUS_SIZE-1:0]  rsp_data,
    output logic                   rsp_error,
    output logic [SRC_SIZE:0]      outstanding,
    output logic [1:0]             err_status
);

    localparam int NSRC     = 1 << SRC_SIZE;
    localparam int DW       = 8 * BUS_SIZE;
    localparam int MAX_SIZE = $clog2(BUS_SIZE);

    logic [NSRC-1:0]       r_busy;
    logic                  r_run;
    logic                  r_a_valid;
    logic [2:0]            r_a_opcode;
    logic [3:0]            r_a_size;
    logic [SRC_SIZE-1:0]   r_a_source;
    logic [ADR_WIDTH-1:0]  r_a_address;
    logic [BUS_SIZE-1:0]   r_a_mask;
    logic [DW-1:0]         r_a_data;
    logic                  r_rsp_valid;
    logic [SRC_SIZE-1:0]   r_rsp_source;
    logic                  r_rsp_write;
    logic [DW-1:0]         r_rsp_data;
    logic                  r_rsp_error;
    logic [1:0]            r_err;

    logic                  w_any_free;
    logic [SRC_SIZE-1:0]   w_free_idx;
    logic                  w_cmd_fire;
    logic                  w_size_ok;
    logic                  w_cmd_ok;
    logic                  w_d_fire;
    logic                  w_d_hit;
    logic                  w_d_stray;
    logic                  w_d_ack;
    logic [NSRC-1:0]       w_busy_nxt;
    logic [SRC_SIZE:0]     w_count;
    logic                  w_unused;

    assign w_unused = ^{d_bits_param, d_bits_size, d_bits_sink};

    // Descending scan so the lowest clear bit wins.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_any_free = 1'b1;
                w_free_idx = SRC_SIZE'(i);
            end
        end
    end

    // r_run keeps both ready outputs low while reset is asserted.
    assign cmd_ready  = r_run & w_any_free & (!r_a_valid | a_ready);
    assign d_ready    = r_run & (!r_rsp_valid | rsp_ready);
    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_size_ok  = (cmd_size <= 4'(MAX_SIZE));
    assign w_cmd_ok   = w_cmd_fire & w_size_ok;
    assign w_d_fire   = d_valid & d_ready;
    assign w_d_hit    = w_d_fire & r_busy[d_bits_source];
    assign w_d_stray  = w_d_fire & !r_busy[d_bits_source];
    assign w_d_ack    = (d_bits_opcode == 3'd0);

    // Set and clear never target the same ID: set only hits a free ID, clear only a busy one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_cmd_ok) w_busy_nxt[w_free_idx] = 1'b1;
        if (w_d_hit)  w_busy_nxt[d_bits_source] = 1'b0;
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_count = w_count + (SRC_SIZE + 1)'(r_busy[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run  <= 1'b0;
            r_busy <= '0;
            r_err  <= 2'b00;
        end else begin
            r_run  <= 1'b1;
            r_busy <= w_busy_nxt;
            if (w_d_stray)               r_err[0] <= 1'b1;
            if (w_cmd_fire & !w_size_ok) r_err[1] <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_valid   <= 1'b0;
            r_a_opcode  <= 3'd0;
            r_a_size    <= 4'd0;
            r_a_source  <= '0;
            r_a_address <= '0;
            r_a_mask    <= '0;
            r_a_data    <= '0;
        end else if (w_cmd_ok) begin
            r_a_valid   <= 1'b1;
            r_a_opcode  <= cmd_write ? 3'd0 : 3'd4;
            r_a_size    <= cmd_size;
            r_a_source  <= w_free_idx;
            r_a_address <= cmd_address;
            r_a_mask    <= cmd_mask;
            r_a_data    <= cmd_write ? cmd_data : '0;
        end else if (a_ready) begin
            r_a_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_source <= '0;
            r_rsp_write  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_error  <= 1'b0;
        end else if (w_d_hit) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_source <= d_bits_source;
            r_rsp_write  <= w_d_ack;
            r_rsp_data   <= w_d_ack ? '0 : d_bits_data;
            r_rsp_error  <= d_bits_denied | d_bits_corrupt;
        end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign a_valid        = r_a_valid;
    assign a_bits_opcode  = r_a_opcode;
    assign a_bits_param   = 3'd0;
    assign a_bits_size    = r_a_size;
    assign a_bits_source  = r_a_source;
    assign a_bits_address = r_a_address;
    assign a_bits_mask    = r_a_mask;
    assign a_bits_data    = r_a_data;
    assign a_bits_corrupt = 1'b0;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_source     = r_rsp_source;
    assign rsp_write      = r_rsp_write;
    assign rsp_data       = r_rsp_data;
    assign rsp_error      = r_rsp_error;
    assign outstanding    = w_count;
    assign err_status     = r_err;

endmodule

// File: tb/tb_tl_ul_master_engine.sv
// Bench for tl_ul_master_engine: driver tasks feed cmd/D streams, a reference model of the
// busy table predicts A beats and responses, and monitors pop the expected queues.
module tb_tl_ul_master_engine;

    localparam int SRC = 2;
    localparam int ADR = 32;
    localparam int BSZ = 8;
    localparam int DW  = 64;
    localparam int AW  = 3 + 4 + SRC + ADR + BSZ + DW + 3 + 1;
    localparam int RW  = SRC + 1 + 1 + DW;

    logic            clock;
    logic            reset_n;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [3:0]      cmd_size;
    logic [ADR-1:0]  cmd_address;
    logic [BSZ-1:0]  cmd_mask;
    logic [DW-1:0]   cmd_data;
    logic            a_ready, a_valid;
    logic [2:0]      a_bits_opcode, a_bits_param;
    logic [3:0]      a_bits_size;
    logic [SRC-1:0]  a_bits_source;
    logic [ADR-1:0]  a_bits_address;
    logic [BSZ-1:0]  a_bits_mask;
    logic [DW-1:0]   a_bits_data;
    logic            a_bits_corrupt;
    logic            d_ready, d_valid;
    logic [2:0]      d_bits_opcode;
    logic [1:0]      d_bits_param;
    logic [3:0]      d_bits_size;
    logic [SRC-1:0]  d_bits_source;
    logic [1:0]      d_bits_sink;
    logic            d_bits_denied, d_bits_corrupt;
    logic [DW-1:0]   d_bits_data;
    logic            rsp_valid, rsp_ready;
    logic [SRC-1:0]  rsp_source;
    logic            rsp_write, rsp_error;
    logic [DW-1:0]   rsp_data;
    logic [SRC:0]    outstanding;
    logic [1:0]      err_status;

    tl_ul_master_engine #(.SRC_SIZE(SRC), .SINK_SIZE(2), .BUS_SIZE(BSZ), .ADR_WIDTH(ADR)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_size(cmd_size),
        .cmd_address(cmd_address), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
        .a_ready(a_ready), .a_valid(a_valid), .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param),
        .a_bits_size(a_bits_size), .a_bits_source(a_bits_source), .a_bits_address(a_bits_address),
        .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data), .a_bits_corrupt(a_bits_corrupt),
        .d_ready(d_ready), .d_valid(d_valid), .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param),
        .d_bits_size(d_bits_size), .d_bits_source(d_bits_source), .d_bits_sink(d_bits_sink),
        .d_bits_denied(d_bits_denied), .d_bits_data(d_bits_data), .d_bits_corrupt(d_bits_corrupt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_source(rsp_source), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .outstanding(outstanding), .err_status(err_status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int a_beats = 0;
    logic [AW-1:0] exp_a_q[$];
    logic [RW-1:0] exp_rsp_q[$];
    logic [3:0]    m_busy = '0;
    logic [1:0]    m_err  = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int popcnt(input logic [3:0] b);
        return int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
    endfunction

    always @(negedge clock) begin
        if (reset_n === 1'b1 && a_valid && a_ready) begin
            a_beats++;
            if (exp_a_q.size() == 0) check("a_unexpected", 1, 0);
            else check("a_beat", {a_bits_opcode, a_bits_size, a_bits_source, a_bits_address, a_bits_mask,
                                  a_bits_data, a_bits_param, a_bits_corrupt}, exp_a_q.pop_front());
        end
    end

    always @(negedge clock) begin
        if (reset_n === 1'b1 && rsp_valid && rsp_ready) begin
            if (exp_rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp", {rsp_source, rsp_write, rsp_error, rsp_data}, exp_rsp_q.pop_front());
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_outstanding"}, outstanding, popcnt(m_busy));
        check({tag, "_err"}, err_status, m_err);
    endtask

    task automatic send_cmd(input logic wr, input logic [3:0] sz, input logic [ADR-1:0] adr,
                            input logic [BSZ-1:0] msk, input logic [DW-1:0] dat, output logic [SRC-1:0] src);
        bit fired = 0;
        bit found = 0;
        src = '0;
        @(posedge clock); #1;
        cmd_valid = 1; cmd_write = wr; cmd_size = sz; cmd_address = adr; cmd_mask = msk; cmd_data = dat;
        for (int c = 0; c < 50 && !fired; c++) begin
            @(negedge clock);
            if (cmd_ready) fired = 1;
            else begin @(posedge clock); #1; end
        end
        if (!fired) check("cmd_timeout", 0, 1);
        else if (sz > 4'd3) m_err[1] = 1'b1;
        else begin
            for (int i = 3; i >= 0; i--) if (!m_busy[i]) begin found = 1; src = SRC'(i); end
            if (!found) check("cmd_accepted_when_full", 1, 0);
            else begin
                m_busy[src] = 1'b1;
                exp_a_q.push_back({(wr ? 3'd0 : 3'd4), sz, src, adr, msk, (wr ? dat : 64'd0), 3'd0, 1'b0});
            end
        end
        @(posedge clock); #1;
        cmd_valid = 0;
    endtask

    task automatic send_d(input logic [SRC-1:0] src, input logic [2:0] opc, input logic [DW-1:0] dat,
                          input logic den);
        bit fired = 0;
        @(posedge clock); #1;
        d_valid = 1; d_bits_source = src; d_bits_opcode = opc; d_bits_data = dat; d_bits_denied = den;
        d_bits_corrupt = 0; d_bits_sink = 2'($urandom_range(0, 3)); d_bits_size = 4'd3;
        for (int c = 0; c < 50 && !fired; c++) begin
            @(negedge clock);
            if (d_ready) fired = 1;
            else begin @(posedge clock); #1; end
        end
        if (!fired) check("d_timeout", 0, 1);
        else if (m_busy[src]) begin
            m_busy[src] = 1'b0;
            exp_rsp_q.push_back({src, (opc == 3'd0), den, (opc == 3'd0 ? 64'd0 : dat)});
        end else m_err[0] = 1'b1;
        @(posedge clock); #1;
        d_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    logic [SRC-1:0] s, s0, s1;
    logic [AW-1:0]  held;
    int beats0;

    initial begin
        reset_n = 0; cmd_valid = 0; cmd_write = 0; cmd_size = 0; cmd_address = 0; cmd_mask = 0; cmd_data = 0;
        a_ready = 1; d_valid = 0; d_bits_opcode = 0; d_bits_param = 0; d_bits_size = 0; d_bits_source = 0;
        d_bits_sink = 0; d_bits_denied = 0; d_bits_data = 0; d_bits_corrupt = 0; rsp_ready = 1;
        #3;
        check("reset_outputs", {a_valid, cmd_ready, d_ready, rsp_valid, outstanding, err_status}, 0);
        #9 reset_n = 1;

        // Single Get round trip
        send_cmd(0, 4'd3, 32'h8000_0000, 8'hFF, 64'h1234, s);
        check("t1_source", s, 0);
        settle(1);
        check_model("t1_busy");
        send_d(s, 3'd1, 64'hDEAD_BEEF, 0);
        settle(2);
        check_model("t1_done");

        // Fill every source, then free ID 2 and reuse it
        for (int i = 0; i < 4; i++)
            send_cmd(1, 4'(i), 32'h1000 + 32'(i * 8), 8'($urandom_range(1, 255)), {$urandom, $urandom}, s);
        settle(2);
        check_model("t2_full");
        check("t2_cmd_ready_full", cmd_ready, 0);
        send_d(2'd2, 3'd0, 64'h0, 0);
        settle(1);
        check("t2_cmd_ready_freed", cmd_ready, 1);
        send_cmd(1, 4'd2, 32'h2000, 8'h0F, 64'hCAFE, s);
        check("t2_reuse_source", s, 2);
        for (int i = 0; i < 4; i++) send_d(SRC'(i), 3'd0, 64'h0, 0);
        settle(2);
        check_model("t2_drain");

        // A-channel backpressure
        a_ready = 0;
        send_cmd(1, 4'd3, 32'h3000, 8'hAA, 64'h0123_4567_89AB_CDEF, s);
        held = exp_a_q[0];
        beats0 = a_beats;
        repeat (5) begin
            @(negedge clock);
            check("t3_a_valid_held", a_valid, 1);
            check("t3_a_fields_stable", {a_bits_opcode, a_bits_size, a_bits_source, a_bits_address, a_bits_mask,
                                         a_bits_data, a_bits_param, a_bits_corrupt}, held);
            check("t3_cmd_ready_blocked", cmd_ready, 0);
        end
        @(posedge clock); #1 a_ready = 1;
        settle(2);
        check("t3_one_beat", a_beats - beats0, 1);
        check("t3_a_valid_drop", a_valid, 0);
        send_d(s, 3'd0, 64'h0, 0);
        settle(2);

        // Stray D beat and oversize command
        send_d(2'd1, 3'd0, 64'h0, 0);
        settle(1);
        check_model("t4_stray");
        check("t4_rsp_idle", rsp_valid, 0);
        beats0 = a_beats;
        send_cmd(0, 4'd6, 32'h4000, 8'hFF, 64'h0, s);
        settle(2);
        check_model("t4_oversize");
        check("t4_no_beat", a_beats - beats0, 0);

        // Response backpressure with a denied access
        rsp_ready = 0;
        send_cmd(0, 4'd3, 32'h5000, 8'hFF, 64'h0, s0);
        send_cmd(0, 4'd2, 32'h5008, 8'h0F, 64'h0, s1);
        settle(2);
        send_d(s0, 3'd1, 64'h1111_2222_3333_4444, 0);
        settle(1);
        check("t5_rsp_held", rsp_valid, 1);
        check("t5_d_ready_blocked", d_ready, 0);
        fork
            send_d(s1, 3'd1, 64'h5555_6666_7777_8888, 1);
            begin repeat (4) @(posedge clock); #1 rsp_ready = 1; end
        join
        settle(3);
        check("t5_rsp_drained", exp_rsp_q.size(), 0);
        check_model("t5_done");

        // Reset with accesses in flight
        for (int i = 0; i < 3; i++) send_cmd(0, 4'd3, 32'h6000 + 32'(i * 8), 8'hFF, 64'h0, s);
        settle(2);
        check_model("t6_pre");
        #2 reset_n = 0;
        #1;
        check("t6_outputs_zero", {a_valid, cmd_ready, d_ready, rsp_valid, err_status, a_bits_source,
                                  a_bits_address, rsp_data}, 0);
        check("t6_outstanding_zero", outstanding, 0);
        m_busy = '0; m_err = '0; exp_a_q.delete(); exp_rsp_q.delete();
        settle(2);
        #2 reset_n = 1;
        send_d(2'd1, 3'd1, 64'h9, 0);
        settle(2);
        check_model("t6_forgotten");
        check("t6_rsp_idle", rsp_valid, 0);

        check("end_a_queue", exp_a_q.size(), 0);
        check("end_rsp_queue", exp_rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
